// File: rtl/cache_pkg.sv
// Shared defaults and state encoding for the single-line cache read buffer.
package cache_pkg;

    localparam int DEFAULT_ADDR_W     = 12;
    localparam int DEFAULT_DATA_W     = 32;
    localparam int DEFAULT_LINE_WORDS = 4;
    localparam int DEFAULT_OFFSET_W   = $clog2(DEFAULT_LINE_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/read_buffer_line_store.sv
// Register array holding one cache line: indexed write port, combinational indexed read port.
module read_buffer_line_store #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] words [LINE_WORDS];

    // Contents need no reset; the owner's line_valid flag decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[wr_idx] <= wr_data;
        end
    end

    assign rd_data = words[rd_idx];

endmodule

// File: rtl/cache_read_buffer.sv
// Single-line read buffer in front of block RAM: one-cycle hits, sequential line fill on a miss.
module cache_read_buffer
    import cache_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int LINE_WORDS = DEFAULT_LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              inval,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              hit,
    output logic              busy
);

    localparam int OFFSET_W = $clog2(LINE_WORDS);
    localparam int TAG_W    = ADDR_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_IDX  = OFFSET_W'(LINE_WORDS - 1);
    localparam logic [OFFSET_W:0]   LINE_CNT  = (OFFSET_W + 1)'(LINE_WORDS);

    state_t state, state_next;

    logic                line_valid;
    logic                inval_pending;
    logic                rd_pending;
    logic [TAG_W-1:0]    stored_tag;
    logic [TAG_W-1:0]    fill_tag;
    logic [OFFSET_W-1:0] fill_offset;
    logic [OFFSET_W-1:0] cap_idx;
    logic [OFFSET_W:0]   issue_cnt;

    logic [TAG_W-1:0]    req_tag;
    logic [OFFSET_W-1:0] req_offset;
    logic                accept;
    logic                is_hit;
    logic                last_capture;
    logic                store_wr;
    logic [OFFSET_W-1:0] rd_idx;
    logic [DATA_W-1:0]   rd_data;

    assign req_tag      = req_addr[ADDR_W-1:OFFSET_W];
    assign req_offset   = req_addr[OFFSET_W-1:0];
    assign accept       = req_valid && req_ready;
    assign is_hit       = line_valid && (req_tag == stored_tag) && !inval;
    assign store_wr     = (state == FILL) && rd_pending;
    assign last_capture = store_wr && (cap_idx == LAST_IDX);
    assign rd_idx       = (state == IDLE) ? req_offset : fill_offset;

    read_buffer_line_store #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (OFFSET_W)
    ) u_line_store (
        .clk     (clk),
        .wr_en   (store_wr),
        .wr_idx  (cap_idx),
        .wr_data (bram_rdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_hit ? RESP : FILL;
                end
            end
            FILL: begin
                if (last_capture) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state == IDLE);
        busy      = (state != IDLE);
    end

    // BRAM data trails its address by one cycle, so rd_pending marks cycles carrying a fill word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_valid    <= 1'b0;
            inval_pending <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            bram_en       <= 1'b0;
            bram_addr     <= '0;
            hit           <= 1'b0;
            rd_pending    <= 1'b0;
            issue_cnt     <= '0;
            cap_idx       <= '0;
            stored_tag    <= '0;
            fill_tag      <= '0;
            fill_offset   <= '0;
        end else begin
            hit        <= 1'b0;
            rd_pending <= bram_en;
            case (state)
                IDLE: begin
                    if (inval) begin
                        line_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (is_hit) begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= rd_data;
                            hit       <= 1'b1;
                        end else begin
                            bram_en     <= 1'b1;
                            bram_addr   <= {req_tag, {OFFSET_W{1'b0}}};
                            issue_cnt   <= (OFFSET_W + 1)'(1);
                            cap_idx     <= '0;
                            line_valid  <= 1'b0;
                            fill_tag    <= req_tag;
                            fill_offset <= req_offset;
                        end
                    end
                end
                FILL: begin
                    if (inval) begin
                        inval_pending <= 1'b1;
                    end
                    if (issue_cnt < LINE_CNT) begin
                        bram_addr <= bram_addr + ADDR_W'(1);
                        issue_cnt <= issue_cnt + (OFFSET_W + 1)'(1);
                    end else begin
                        bram_en <= 1'b0;
                    end
                    if (store_wr) begin
                        cap_idx <= cap_idx + OFFSET_W'(1);
                    end
                    // The last word is still on bram_rdata, not yet in the store.
                    if (last_capture) begin
                        line_valid <= !(inval_pending || inval);
                        stored_tag <= fill_tag;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= (fill_offset == LAST_IDX) ? bram_rdata : rd_data;
                    end
                end
                RESP: begin
                    if (inval) begin
                        line_valid <= 1'b0;
                    end
                    if (rsp_ready) begin
                        rsp_valid     <= 1'b0;
                        inval_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_read_buffer.sv
// Directed self-checking bench for cache_read_buffer with a BRAM model returning addr*3.
module tb_cache_read_buffer;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [11:0] req_addr;
    logic        inval;
    logic        bram_en;
    logic [11:0] bram_addr;
    logic [31:0] bram_rdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        hit;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] addr_log [$];
    logic        hit_seen;
    int          edges;
    logic [31:0] held_data;

    cache_read_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .inval      (inval),
        .bram_en    (bram_en),
        .bram_addr  (bram_addr),
        .bram_rdata (bram_rdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .hit        (hit),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bram_en) begin
            bram_rdata <= 32'(bram_addr) * 32'd3;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request; inval_at = 0 raises inval with the accept, n > 0 raises it n edges later.
    task automatic apply_stimulus(input logic [11:0] addr, input int inval_at, output int n_edges);
        int n;
        n = 0;
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        req_addr  = addr;
        req_valid = 1'b1;
        inval     = (inval_at == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        inval     = 1'b0;
        n_edges   = 1;
        hit_seen  = 1'b0;
        addr_log.delete();
        while (1) begin
            inval = (n_edges == inval_at);
            if (bram_en) addr_log.push_back(bram_addr);
            if (hit) hit_seen = 1'b1;
            if (rsp_valid || n_edges >= 20) break;
            @(negedge clk);
            n_edges++;
        end
        inval = 1'b0;
    endtask

    task automatic check_fill(input string tag, input logic [11:0] base);
        logic [31:0] got;
        check_output({tag, "_nwords"}, 32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            got = (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hxxxxxxxx;
            check_output({tag, "_addr"}, got, 32'(base) + 32'(i));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_addr  = 12'h013;
        inval     = 1'b0;
        rsp_ready = 1'b1;

        // 1: reset holds everything idle even with a pending request
        repeat (3) @(negedge clk);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_bram_en", 32'(bram_en), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_hit", 32'(hit), 32'd0);
        check_output("rst_rsp_data", rsp_data, 32'd0);
        check_output("rst_bram_addr", 32'(bram_addr), 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check_output("post_rst_ready", 32'(req_ready), 32'd1);

        // 2: cold miss
        apply_stimulus(12'h013, -1, edges);
        check_output("t2_latency", 32'(edges), 32'd6);
        check_output("t2_rsp_data", rsp_data, 32'h039);
        check_output("t2_hit", 32'(hit_seen), 32'd0);
        check_fill("t2_fill", 12'h010);

        // 3: hit in the freshly filled line
        @(negedge clk);
        apply_stimulus(12'h011, -1, edges);
        check_output("t3_latency", 32'(edges), 32'd1);
        check_output("t3_rsp_data", rsp_data, 32'h033);
        check_output("t3_hit", 32'(hit), 32'd1);
        check_output("t3_no_bram", 32'(addr_log.size()), 32'd0);
        @(negedge clk);
        check_output("t3_hit_pulse", 32'(hit), 32'd0);
        check_output("t3_bram_idle", 32'(bram_en), 32'd0);

        // 4: backpressure on a hit response
        rsp_ready = 1'b0;
        apply_stimulus(12'h012, -1, edges);
        check_output("t4_latency", 32'(edges), 32'd1);
        check_output("t4_rsp_data", rsp_data, 32'h036);
        held_data = rsp_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("t4_hold_valid", 32'(rsp_valid), 32'd1);
            check_output("t4_hold_data", rsp_data, held_data);
            check_output("t4_hold_ready", 32'(req_ready), 32'd0);
            check_output("t4_hold_busy", 32'(busy), 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("t4_release_valid", 32'(rsp_valid), 32'd0);
        check_output("t4_release_ready", 32'(req_ready), 32'd1);

        // 5: inval during the second fill word leaves the line invalid
        apply_stimulus(12'h020, 2, edges);
        check_output("t5_latency", 32'(edges), 32'd6);
        check_output("t5_rsp_data", rsp_data, 32'h060);
        check_fill("t5_fill", 12'h020);
        @(negedge clk);
        apply_stimulus(12'h021, -1, edges);
        check_output("t5_refill_latency", 32'(edges), 32'd6);
        check_output("t5_refill_data", rsp_data, 32'h063);
        check_fill("t5_refill", 12'h020);
        @(negedge clk);
        apply_stimulus(12'h023, -1, edges);
        check_output("t5_hit_latency", 32'(edges), 32'd1);
        check_output("t5_hit_data", rsp_data, 32'h069);

        // inval together with an accepted request forces a miss
        @(negedge clk);
        apply_stimulus(12'h022, 0, edges);
        check_output("t5_inval_accept_latency", 32'(edges), 32'd6);
        check_output("t5_inval_accept_data", rsp_data, 32'h066);
        check_output("t5_inval_accept_hit", 32'(hit_seen), 32'd0);
        check_fill("t5_inval_accept", 12'h020);

        // 6: reset during the third fill word aborts the fill
        @(negedge clk);
        check_output("t6_ready", 32'(req_ready), 32'd1);
        req_addr  = 12'h030;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_output("t6_first_addr", 32'(bram_addr), 32'h030);
        @(negedge clk);
        @(negedge clk);
        check_output("t6_third_addr", 32'(bram_addr), 32'h032);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("t6_rst_bram_en", 32'(bram_en), 32'd0);
        check_output("t6_rst_busy", 32'(busy), 32'd0);
        check_output("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(12'h031, -1, edges);
        check_output("t6_refill_latency", 32'(edges), 32'd6);
        check_output("t6_refill_data", rsp_data, 32'h093);
        check_output("t6_refill_hit", 32'(hit_seen), 32'd0);
        check_fill("t6_refill", 12'h030);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
